div_bcd_convert: RTL

//  Downstream stage of the sequential divider. Takes the binary quotient and remainder
//  and converts both to packed BCD in parallel for the decimal display path.

---
 rtl/div_bcd_convert.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/div_bcd_convert.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_bcd_convert                                                 |
// | Purpose  : Converts the divider's binary quotient and remainder to packed  |
// |            BCD in parallel, one double-dabble step per clock, using a      |
// |            load/busy/done handshake.                                       |
// | Options  : DIV_BCD_ZERO_BLANK_EN - leading-zero digits read 4'hF           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module div_bcd_convert #(
    parameter int NBIT   = 16,  // input width (2..31)
    parameter int DIGITS = 5    // BCD digits, 10^DIGITS > 2^NBIT - 1
) (
    input  logic                  clk,
    input  logic                  reset,   // asynchronous, active low
    input  logic                  load,
    input  logic [NBIT-1:0]       Q_in,
    input  logic [NBIT-1:0]       R_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   Q_bcd,
    output logic [4*DIGITS-1:0]   R_bcd
);

    localparam int c_CNT_W = $clog2(NBIT) + 1;
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CAT_W = c_BCD_W + NBIT;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NBIT - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CONVERT = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

`ifdef DIV_BCD_ZERO_BLANK_EN
    // A cleared display shows only digit 0, everything above it blanked.
    localparam logic [c_BCD_W-1:0] c_OUT_RST = {{(DIGITS-1){4'hF}}, 4'h0};
`else
    localparam logic [c_BCD_W-1:0] c_OUT_RST = '0;
`endif

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [NBIT-1:0]     r_q_bin;
    logic [NBIT-1:0]     r_r_bin;
    logic [c_BCD_W-1:0]  r_q_bcd;
    logic [c_BCD_W-1:0]  r_r_bcd;
    logic                w_accept;
    logic                w_last;
    logic [c_CAT_W-1:0]  w_q_cat;
    logic [c_CAT_W-1:0]  w_r_cat;
    logic [c_BCD_W-1:0]  w_q_res;
    logic [c_BCD_W-1:0]  w_r_res;

    // Add 3 to every digit that is 5 or more, so the following shift carries correctly.
    function automatic logic [c_BCD_W-1:0] f_add3(input logic [c_BCD_W-1:0] bcd);
        logic [c_BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

`ifdef DIV_BCD_ZERO_BLANK_EN
    // Replace leading zero digits with the blank code; digit 0 is always shown.
    function automatic logic [c_BCD_W-1:0] f_blank(input logic [c_BCD_W-1:0] bcd);
        logic [c_BCD_W-1:0] res;
        logic               lead;
        res  = bcd;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (bcd[4*i +: 4] == 4'd0)) begin
                res[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return res;
    endfunction
`endif

    // A new conversion may start from any state except an in-flight one.
    assign w_accept = load && (r_state != c_CONVERT);
    assign w_last   = (r_cnt == c_LAST);

    // One double-dabble step: adjust digits, then shift {bcd,bin} left by one.
    assign w_q_cat = {f_add3(r_q_bcd), r_q_bin} << 1;
    assign w_r_cat = {f_add3(r_r_bcd), r_r_bin} << 1;

`ifdef DIV_BCD_ZERO_BLANK_EN
    assign w_q_res = f_blank(w_q_cat[c_CAT_W-1 -: c_BCD_W]);
    assign w_r_res = f_blank(w_r_cat[c_CAT_W-1 -: c_BCD_W]);
`else
    assign w_q_res = w_q_cat[c_CAT_W-1 -: c_BCD_W];
    assign w_r_res = w_r_cat[c_CAT_W-1 -: c_BCD_W];
`endif

    assign busy = (r_state == c_CONVERT);
    assign done = (r_state == c_DONE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (w_accept) w_next_state = c_CONVERT;
            c_CONVERT: if (w_last)   w_next_state = c_DONE;
            c_DONE:    w_next_state = w_accept ? c_CONVERT : c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    // Working registers, step counter and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_q_bin <= '0;
            r_r_bin <= '0;
            r_q_bcd <= '0;
            r_r_bcd <= '0;
            Q_bcd   <= c_OUT_RST;
            R_bcd   <= c_OUT_RST;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_q_bin <= Q_in;
            r_r_bin <= R_in;
            r_q_bcd <= '0;
            r_r_bcd <= '0;
        end else if (r_state == c_CONVERT) begin
            r_cnt   <= r_cnt + 1'b1;
            r_q_bin <= w_q_cat[NBIT-1:0];
            r_r_bin <= w_r_cat[NBIT-1:0];
            r_q_bcd <= w_q_cat[c_CAT_W-1 -: c_BCD_W];
            r_r_bcd <= w_r_cat[c_CAT_W-1 -: c_BCD_W];
            if (w_last) begin
                Q_bcd <= w_q_res;
                R_bcd <= w_r_res;
            end
        end
    end

endmodule
`default_nettype wire
